// File: rtl/urv_timer_irq.sv
// Multi-channel countdown timer and interrupt source on the uRV data-memory bus.
// Channels share one prescaler; irq_o is the registered OR of (pending & irq_en).
module urv_timer_irq #(
   parameter int          g_num_channels  = 4,
   parameter int          g_counter_width = 16,
   parameter logic [31:0] g_base_addr     = 32'h00100100
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] dm_addr_i,
   input  logic [31:0] dm_data_s_i,
   input  logic [3:0]  dm_data_select_i,
   input  logic        dm_store_i,
   input  logic        dm_load_i,
   output logic [31:0] dm_data_l_o,
   output logic        dm_store_done_o,
   output logic        dm_load_done_o,
   output logic        irq_o
);
   localparam int N = g_num_channels;
   localparam int W = g_counter_width;
   localparam logic [11:0]  c_base_lo = g_base_addr[11:0];
   localparam logic [W-1:0] c_one     = W'(1);

   logic [11:0] off;
   logic [7:0]  slot;
   logic [1:0]  sub;
   logic        reg_ok, hit, st_hit, ld_hit, tick;
   logic [31:0] wr_mask;

   // Offset is relative to the base so an unaligned-in-page base still works.
   assign off     = dm_addr_i[11:0] - c_base_lo;
   assign slot    = off[11:4];
   assign sub     = off[3:2];
   assign reg_ok  = (off[1:0] == 2'b00) &&
                    (((slot == 8'd0) && (sub <= 2'd1)) ||
                     ((slot != 8'd0) && (slot <= 8'(N)) && (sub != 2'd3)));
   assign hit     = (dm_addr_i[31:12] == g_base_addr[31:12]) && reg_ok;
   assign st_hit  = hit && dm_store_i;
   assign ld_hit  = hit && dm_load_i && !dm_store_i;
   assign wr_mask = {{8{dm_data_select_i[3]}}, {8{dm_data_select_i[2]}},
                     {8{dm_data_select_i[1]}}, {8{dm_data_select_i[0]}}};

   function automatic logic [31:0] f_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [31:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   logic [15:0]  presc_q, presc_d, presc_cnt_q, presc_cnt_d;
   logic [N-1:0] en_q, en_d, per_q, per_d, ie_q, ie_d, pend_q, pend_d;
   logic [W-1:0] reload_q [N];
   logic [W-1:0] reload_d [N];
   logic [W-1:0] count_q  [N];
   logic [W-1:0] count_d  [N];
   logic         irq_q, irq_d, st_done_q, ld_done_q;
   logic [31:0]  ld_data_q, ld_data_d, rd_data, wr_tmp;

   assign tick = (presc_cnt_q == 16'd0);

   always_comb begin
      presc_d     = presc_q;
      presc_cnt_d = tick ? presc_q : presc_cnt_q - 16'd1;
      en_d        = en_q;
      per_d       = per_q;
      ie_d        = ie_q;
      pend_d      = pend_q;
      reload_d    = reload_q;
      count_d     = count_q;
      wr_tmp      = '0;

      if (st_hit && slot == 8'd0 && sub == 2'd1) begin
         wr_tmp      = f_merge({16'd0, presc_q}, dm_data_s_i, wr_mask);
         presc_d     = wr_tmp[15:0];
         presc_cnt_d = wr_tmp[15:0];
      end

      for (int c = 0; c < N; c++) begin
         // Clear before set so an expiry in the same cycle as W1C leaves pending set.
         if (st_hit && slot == 8'd0 && sub == 2'd0 && (dm_data_s_i[c] & wr_mask[c]))
            pend_d[c] = 1'b0;

         if (en_q[c] && tick) begin
            if (count_q[c] > c_one) begin
               count_d[c] = count_q[c] - c_one;
            end else if (count_q[c] == c_one) begin
               pend_d[c] = 1'b1;
               if (per_q[c]) begin
                  count_d[c] = reload_q[c];
               end else begin
                  count_d[c] = '0;
                  en_d[c]    = 1'b0;
               end
            end
         end

         if (st_hit && slot == 8'(c + 1) && sub == 2'd1) begin
            wr_tmp      = f_merge(32'(reload_q[c]), dm_data_s_i, wr_mask);
            reload_d[c] = wr_tmp[W-1:0];
            count_d[c]  = wr_tmp[W-1:0];
         end

         if (st_hit && slot == 8'(c + 1) && sub == 2'd0 && dm_data_select_i[0]) begin
            en_d[c]  = dm_data_s_i[0];
            per_d[c] = dm_data_s_i[1];
            ie_d[c]  = dm_data_s_i[2];
            if (dm_data_s_i[0]) begin
               count_d[c] = reload_q[c];
               if (reload_q[c] == '0)
                  en_d[c] = 1'b0;
            end
         end
      end

      irq_d = |(pend_d & ie_d);
   end

   always_comb begin
      rd_data = '0;
      if (slot == 8'd0) begin
         if (sub == 2'd0)
            rd_data[N-1:0] = pend_q;
         else if (sub == 2'd1)
            rd_data[15:0] = presc_q;
      end
      for (int c = 0; c < N; c++) begin
         if (slot == 8'(c + 1)) begin
            case (sub)
               2'd0:    rd_data[2:0]   = {ie_q[c], per_q[c], en_q[c]};
               2'd1:    rd_data[W-1:0] = reload_q[c];
               2'd2:    rd_data[W-1:0] = count_q[c];
               default: rd_data        = '0;
            endcase
         end
      end
      ld_data_d = ld_hit ? rd_data : 32'd0;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         presc_q     <= '0;
         presc_cnt_q <= '0;
         en_q        <= '0;
         per_q       <= '0;
         ie_q        <= '0;
         pend_q      <= '0;
         irq_q       <= 1'b0;
         st_done_q   <= 1'b0;
         ld_done_q   <= 1'b0;
         ld_data_q   <= '0;
         for (int c = 0; c < N; c++) begin
            reload_q[c] <= '0;
            count_q[c]  <= '0;
         end
      end else begin
         presc_q     <= presc_d;
         presc_cnt_q <= presc_cnt_d;
         en_q        <= en_d;
         per_q       <= per_d;
         ie_q        <= ie_d;
         pend_q      <= pend_d;
         reload_q    <= reload_d;
         count_q     <= count_d;
         irq_q       <= irq_d;
         st_done_q   <= st_hit;
         ld_done_q   <= ld_hit;
         ld_data_q   <= ld_data_d;
      end
   end

   assign dm_data_l_o     = ld_data_q;
   assign dm_store_done_o = st_done_q;
   assign dm_load_done_o  = ld_done_q;
   assign irq_o           = irq_q;

endmodule
